// File: rtl/dart_game_multi_if.sv
// Button input and score/status outputs of the dart game core, bundled as one port.
// The master side drives throw_button; the slave side (the core) drives everything else.
interface dart_game_multi_if #(
    parameter int SCORE_W = 8
);
    logic               throw_button;
    logic [2:0]         player_id;
    logic [5:0]         throw_score;
    logic               throw_valid;
    logic [SCORE_W-1:0] score_display;
    logic [SCORE_W-1:0] final_score;
    logic [2:0]         winner_id;
    logic               game_over;

    modport master (
        output throw_button,
        input  player_id, throw_score, throw_valid, score_display,
        input  final_score, winner_id, game_over
    );

    modport slave (
        input  throw_button,
        output player_id, throw_score, throw_valid, score_display,
        output final_score, winner_id, game_over
    );
endinterface

// File: rtl/dart_game_multi.sv
// Multi-player dart game core: LFSR throw scores, per-player saturating totals, winner search.
// Optional macro DART_DOUBLE_EN enables the double ring (lfsr[5] doubles a valid throw).
module dart_game_multi #(
    parameter int          NUM_PLAYERS     = 4,
    parameter int          THROWS_PER_TURN = 3,
    parameter int          NUM_ROUNDS      = 3,
    parameter int          SCORE_W         = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    dart_game_multi_if.slave bus
);
    localparam int TW    = $clog2(THROWS_PER_TURN + 1);
    localparam int RW    = $clog2(NUM_ROUNDS + 1);
    localparam int SUM_W = ((SCORE_W > 6) ? SCORE_W : 6) + 1;

    localparam logic [TW-1:0]      LAST_THROW  = TW'(THROWS_PER_TURN - 1);
    localparam logic [RW-1:0]      LAST_ROUND  = RW'(NUM_ROUNDS - 1);
    localparam logic [2:0]         LAST_PLAYER = 3'(NUM_PLAYERS - 1);
    localparam logic [SCORE_W-1:0] MAX_SCORE   = '1;
    localparam logic [SUM_W-1:0]   MAX_SUM     = SUM_W'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, PLAY, SEARCH, DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               btn_q;
    logic [TW-1:0]      throw_cnt_q, throw_cnt_d;
    logic [RW-1:0]      round_q, round_d;
    logic [2:0]         player_q, player_d;
    logic               adv_q, adv_d;
    logic [SCORE_W-1:0] total_q [8];
    logic [SCORE_W-1:0] total_d [8];
    logic [2:0]         search_idx_q, search_idx_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic [2:0]         best_id_q, best_id_d;
    logic [5:0]         throw_score_q, throw_score_d;
    logic               throw_valid_q, throw_valid_d;
    logic [SCORE_W-1:0] final_score_q, final_score_d;
    logic [2:0]         winner_id_q, winner_id_d;
    logic               game_over_q, game_over_d;

    logic               throw_edge;
    logic [4:0]         raw;
    logic [5:0]         score;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] cand;

    always_comb begin
        raw   = lfsr_q[4:0];
        score = 6'd0;
        if (raw <= 5'd20) begin
`ifdef DART_DOUBLE_EN
            score = lfsr_q[5] ? {raw, 1'b0} : {1'b0, raw};
`else
            score = {1'b0, raw};
`endif
        end
    end

    // A finished turn is applied one cycle late so the thrower's new total is shown first.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        throw_cnt_d   = throw_cnt_q;
        round_d       = round_q;
        player_d      = player_q;
        adv_d         = 1'b0;
        total_d       = total_q;
        search_idx_d  = search_idx_q;
        best_d        = best_q;
        best_id_d     = best_id_q;
        throw_score_d = throw_score_q;
        throw_valid_d = 1'b0;
        final_score_d = final_score_q;
        winner_id_d   = winner_id_q;
        game_over_d   = game_over_q;
        throw_edge    = bus.throw_button & ~btn_q;
        sum           = '0;
        cand          = total_q[search_idx_q];

        if (adv_q) begin
            if (player_q == LAST_PLAYER) begin
                player_d = 3'd0;
                round_d  = round_q + 1'b1;
            end else begin
                player_d = player_q + 3'd1;
            end
        end

        case (state_q)
            IDLE, PLAY: begin
                if (throw_edge) begin
                    state_d       = PLAY;
                    throw_valid_d = 1'b1;
                    throw_score_d = score;
                    sum           = SUM_W'(total_q[player_d]) + SUM_W'(score);
                    total_d[player_d] = (sum > MAX_SUM) ? MAX_SCORE : sum[SCORE_W-1:0];
                    if (throw_cnt_q == LAST_THROW) begin
                        throw_cnt_d = '0;
                        if (player_d == LAST_PLAYER && round_d == LAST_ROUND) begin
                            state_d      = SEARCH;
                            search_idx_d = 3'd0;
                        end else begin
                            adv_d = 1'b1;
                        end
                    end else begin
                        throw_cnt_d = throw_cnt_q + 1'b1;
                    end
                end
            end
            SEARCH: begin
                if (search_idx_q == 3'd0 || cand > best_q) begin
                    best_d    = cand;
                    best_id_d = search_idx_q;
                end
                if (search_idx_q == LAST_PLAYER) begin
                    state_d       = DONE;
                    game_over_d   = 1'b1;
                    final_score_d = best_d;
                    winner_id_d   = best_id_d;
                end else begin
                    search_idx_d = search_idx_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        btn_q <= bus.throw_button;
        if (reset) begin
            state_q       <= IDLE;
            lfsr_q        <= LFSR_SEED;
            throw_cnt_q   <= '0;
            round_q       <= '0;
            player_q      <= 3'd0;
            adv_q         <= 1'b0;
            for (int i = 0; i < 8; i++) total_q[i] <= '0;
            search_idx_q  <= 3'd0;
            best_q        <= '0;
            best_id_q     <= 3'd0;
            throw_score_q <= 6'd0;
            throw_valid_q <= 1'b0;
            final_score_q <= '0;
            winner_id_q   <= 3'd0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            throw_cnt_q   <= throw_cnt_d;
            round_q       <= round_d;
            player_q      <= player_d;
            adv_q         <= adv_d;
            total_q       <= total_d;
            search_idx_q  <= search_idx_d;
            best_q        <= best_d;
            best_id_q     <= best_id_d;
            throw_score_q <= throw_score_d;
            throw_valid_q <= throw_valid_d;
            final_score_q <= final_score_d;
            winner_id_q   <= winner_id_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.player_id     = player_q;
    assign bus.throw_score   = throw_score_q;
    assign bus.throw_valid   = throw_valid_q;
    assign bus.score_display = total_q[player_q];
    assign bus.final_score   = final_score_q;
    assign bus.winner_id     = winner_id_q;
    assign bus.game_over     = game_over_q;
endmodule

// File: tb/tb_dart_game_multi.sv
// Directed bench for dart_game_multi: default game, saturation and tie configurations.
// Expected throw scores come from an LFSR model; build with DART_DOUBLE_EN to test the double ring.
module tb_dart_game_multi;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] lfsr_m;

`ifdef DART_DOUBLE_EN
    localparam int DBL_EXP = 34;
`else
    localparam int DBL_EXP = 17;
`endif

    always #5 clk = ~clk;

    dart_game_multi_if #(.SCORE_W(8)) main_if ();
    dart_game_multi_if #(.SCORE_W(5)) sat_if ();
    dart_game_multi_if #(.SCORE_W(8)) tie_if ();

    dart_game_multi u_main (.clk(clk), .reset(reset), .bus(main_if));

    dart_game_multi #(.NUM_PLAYERS(2), .THROWS_PER_TURN(8), .NUM_ROUNDS(1), .SCORE_W(5))
        u_sat (.clk(clk), .reset(reset), .bus(sat_if));

    dart_game_multi #(.NUM_PLAYERS(2), .THROWS_PER_TURN(1), .NUM_ROUNDS(1), .SCORE_W(8))
        u_tie (.clk(clk), .reset(reset), .bus(tie_if));

    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // All three cores share reset, so one model tracks every LFSR.
    always @(posedge clk) lfsr_m <= reset ? 16'hACE1 : lfsrNext(lfsr_m);

    function automatic int expScore(input logic [15:0] s);
        int r;
        r = int'(s[4:0]);
        if (r > 20) return 0;
`ifdef DART_DOUBLE_EN
        if (s[5]) return 2 * r;
`endif
        return r;
    endfunction

    function automatic bit lfsrMatch(input logic [15:0] s, input int mode);
        case (mode)
            1:       return (s[4:0] == 5'd17) && s[5];
            2:       return s[4:0] == 5'd20;
            default: return s[4:0] >= 5'd21;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic setButton(input int sel, input logic v);
        case (sel)
            0:       main_if.throw_button = v;
            1:       sat_if.throw_button  = v;
            default: tie_if.throw_button  = v;
        endcase
    endtask

    task automatic waitFor(input int mode);
        bit found = 0;
        for (int i = 0; i < 1000; i++) begin
            if (lfsrMatch(lfsr_m, mode)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("wait_lfsr", 32'(found), 32'd1);
    endtask

    task automatic applyStimulus(input int sel, output logic [15:0] used);
        used = lfsr_m;
        setButton(sel, 1'b1);
        @(negedge clk);
        setButton(sel, 1'b0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] used;
        int          exp_total [4];
        int          sc, p, np, pulses, lat, best, best_id, exp_s;

        reset = 1'b1;
        main_if.throw_button = 1'b0;
        sat_if.throw_button  = 1'b0;
        tie_if.throw_button  = 1'b0;
        for (int i = 0; i < 4; i++) exp_total[i] = 0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            main_if.throw_button = ~main_if.throw_button;
            tie_if.throw_button  = ~tie_if.throw_button;
        end
        checkOutput("rst_player",  32'(main_if.player_id), 0);
        checkOutput("rst_score",   32'(main_if.throw_score), 0);
        checkOutput("rst_valid",   32'(main_if.throw_valid), 0);
        checkOutput("rst_display", 32'(main_if.score_display), 0);
        checkOutput("rst_final",   32'(main_if.final_score), 0);
        checkOutput("rst_winner",  32'(main_if.winner_id), 0);
        checkOutput("rst_over",    32'(main_if.game_over), 0);
        reset = 1'b0;
        main_if.throw_button = 1'b0;
        tie_if.throw_button  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // First throw: held for 10 cycles at an r=17, lfsr[5]=1 state.
        waitFor(1);
        used   = lfsr_m;
        pulses = 0;
        main_if.throw_button = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (main_if.throw_valid) pulses++;
            if (i == 0) begin
                sc = expScore(used);
                exp_total[0] = sc;
                checkOutput("double_ring", 32'(main_if.throw_score), DBL_EXP);
                checkOutput("first_score", 32'(main_if.throw_score), 32'(sc));
                checkOutput("first_display", 32'(main_if.score_display), 32'(exp_total[0]));
            end
        end
        main_if.throw_button = 1'b0;
        checkOutput("held_pulses", 32'(pulses), 1);
        @(negedge clk);
        @(negedge clk);

        for (int t = 1; t < 36; t++) begin
            applyStimulus(0, used);
            p  = (t / 3) % 4;
            sc = expScore(used);
            exp_total[p] = (exp_total[p] + sc > 255) ? 255 : exp_total[p] + sc;
            checkOutput("play_valid",   32'(main_if.throw_valid), 1);
            checkOutput("play_score",   32'(main_if.throw_score), 32'(sc));
            checkOutput("play_display", 32'(main_if.score_display), 32'(exp_total[p]));
            checkOutput("play_player",  32'(main_if.player_id), 32'(p));
            if (t < 35) begin
                @(negedge clk);
                np = ((t + 1) / 3) % 4;
                checkOutput("next_player",  32'(main_if.player_id), 32'(np));
                checkOutput("next_display", 32'(main_if.score_display), 32'(exp_total[np]));
                @(negedge clk);
            end
        end

        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (main_if.game_over) begin
                lat = k;
                break;
            end
        end
        checkOutput("over_latency", 32'(lat), 4);
        best = exp_total[0];
        best_id = 0;
        for (int i = 1; i < 4; i++) begin
            if (exp_total[i] > best) begin
                best = exp_total[i];
                best_id = i;
            end
        end
        checkOutput("end_player", 32'(main_if.player_id), 3);
        checkOutput("end_winner", 32'(main_if.winner_id), 32'(best_id));
        checkOutput("end_final",  32'(main_if.final_score), 32'(best));

        @(negedge clk);
        applyStimulus(0, used);
        checkOutput("done_valid",   32'(main_if.throw_valid), 0);
        checkOutput("done_display", 32'(main_if.score_display), 32'(exp_total[3]));
        @(negedge clk);
        checkOutput("done_over",    32'(main_if.game_over), 1);
        checkOutput("done_winner",  32'(main_if.winner_id), 32'(best_id));

        // Saturation: SCORE_W=5, eight r=20 throws for player 0.
        exp_s = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            waitFor(2);
            applyStimulus(1, used);
            sc = expScore(used);
            exp_s = (exp_s + sc > 31) ? 31 : exp_s + sc;
            checkOutput("sat_valid",   32'(sat_if.throw_valid), 1);
            checkOutput("sat_display", 32'(sat_if.score_display), 32'(exp_s));
        end
        checkOutput("sat_clamp", 32'(sat_if.score_display), 31);

        // Tie: two misses, lowest id must win with 0.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            waitFor(3);
            applyStimulus(2, used);
            checkOutput("tie_score",  32'(tie_if.throw_score), 0);
            checkOutput("tie_player", 32'(tie_if.player_id), 32'(i));
        end
        for (int k = 0; k < 10; k++) begin
            if (tie_if.game_over) break;
            @(negedge clk);
        end
        checkOutput("tie_over",   32'(tie_if.game_over), 1);
        checkOutput("tie_winner", 32'(tie_if.winner_id), 0);
        checkOutput("tie_final",  32'(tie_if.final_score), 0);

        // Mid-game reset clears everything on the next edge.
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_sat_display", 32'(sat_if.score_display), 0);
        checkOutput("mid_rst_sat_player",  32'(sat_if.player_id), 0);
        checkOutput("mid_rst_main_over",   32'(main_if.game_over), 0);
        checkOutput("mid_rst_main_final",  32'(main_if.final_score), 0);
        checkOutput("mid_rst_tie_over",    32'(tie_if.game_over), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dart_game_multi.md
# dart_game_multi

Parametrised multi-player digital dart game core. It is the successor to the single-configuration dart game and supports configurable player count, throws per turn, rounds and score width. Throw scores come from a free-running LFSR. The core detects rising edges on the throw button, keeps per-player saturating totals, and determines the winner after the final round. It sits between the debounced button input and the score display/LED driver logic.

## Interface
- `NUM_PLAYERS`, default 4: number of players, 2..8.
- `THROWS_PER_TURN`, default 3: throws per player turn, ≥1.
- `NUM_ROUNDS`, default 3: full rotations through all players, ≥1.
- `SCORE_W`, default 8: accumulator width; totals saturate at 2^SCORE_W−1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `throw_button` in 1: level input; each rising edge is one throw.
- `player_id` out 3: current player, 0..NUM_PLAYERS−1.
- `throw_score` out 6: score of the most recent throw.
- `throw_valid` out 1: one-cycle pulse when `throw_score`/`score_display` update.
- `score_display` out SCORE_W: running total of `player_id`.
- `final_score` out SCORE_W: winner's total; valid while `game_over`=1.
- `winner_id` out 3: winning player; valid while `game_over`=1.
- `game_over` out 1: high from end of winner search until reset.

## Operation
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. It shifts every cycle, in every state except during reset.
- Raw throw value: r = lfsr[4:0] sampled on the edge-detect cycle. r ≤ 20 gives score r; r ≥ 21 gives 0 (miss).
- Edge detect: register `throw_button`; a throw is `throw_button & ~btn_q`. Holding the button yields exactly one throw.
- FSM states:
  - IDLE: entered from reset. On the first throw edge, goes to PLAY and scores that throw.
  - PLAY: each throw edge scores the throw. Counters:
    - throw_cnt counts 0..THROWS_PER_TURN−1; on wrap, player_id increments.
    - player_id counts 0..NUM_PLAYERS−1; on wrap, round_cnt increments.
    - When the last throw of the last player of the last round is scored, go to SEARCH.
  - SEARCH: compares totals for ids 0..NUM_PLAYERS−1, one per cycle. Strict greater-than, so ties go to the lowest id. Then go to DONE.
  - DONE: `game_over`=1. Throw edges are ignored (no `throw_valid`, no LFSR capture effect). Exit only via reset.
- Accumulator add: `total[p] + throw_score` with saturation at 2^SCORE_W−1. No wrap.
- `score_display` always shows `total[player_id]`. After a turn change it shows the new player's total.
- During SEARCH and DONE, `player_id` holds NUM_PLAYERS−1.

## Timing
- Reset values:
  - all outputs 0;
  - all totals, throw_cnt and round_cnt 0;
  - lfsr = LFSR_SEED;
  - FSM = IDLE.
- Reset mid-game: everything above is restored on the next edge. Any in-flight throw is discarded.
- Throw edge on `throw_button` sampled at cycle N:
  - `throw_valid`=1 in cycle N+1;
  - `throw_score` and `score_display` reflect the updated total in N+1.
- Turn advance: `player_id` changes at N+2 after the final throw of a turn. `score_display` switches to the next player in the same cycle.
- New edges arriving at N+1 are accepted and counted. At most one throw per cycle, which is inherent to edge detection.
- Game end: SEARCH occupies NUM_PLAYERS cycles after the last `throw_valid`. `game_over`, `winner_id` and `final_score` assert together and stay stable until reset.
- Throw edges during SEARCH are ignored.

## Configuration
- `DART_DOUBLE_EN` defined: double ring is enabled. If r ≤ 20 and lfsr[5]=1, score = 2r (max 40), so all 6 bits of `throw_score` are used.
- `DART_DOUBLE_EN` undefined: score is r or 0 only, and `throw_score[5]` is constant 0.

## Test plan
- Reset: assert `reset` for 2 cycles with the button toggling → all outputs 0 and FSM in IDLE. The first throw scores from lfsr state `ACE1`-derived, checked against the bench LFSR model.
- Held button: hold `throw_button` high for 10 cycles → exactly one `throw_valid` pulse, and `score_display` equals the model score.
- Turn and round rotation: defaults, 36 throws spaced 3 cycles apart. Required response:
  - `player_id` sequence 0,0,0,1,1,1,…,3 repeated 3 times;
  - `game_over` rises 4 cycles after the 36th `throw_valid`;
  - `winner_id`/`final_score` match the model's max, lowest id on tie.
- Saturation: SCORE_W=5, NUM_PLAYERS=2, THROWS_PER_TURN=8, forced LFSR seeds giving r=20 → total clamps at 31, with no wrap to a small value.
- Tie: NUM_PLAYERS=2, THROWS_PER_TURN=1, NUM_ROUNDS=1, seed chosen so both throws score 0 → `winner_id`=0, `final_score`=0, `game_over`=1.
- `DART_DOUBLE_EN`: with the macro defined, a throw at a cycle where r=17 and lfsr[5]=1 gives `throw_score`=34. Without the macro, the same cycle gives 17.
